// File: rtl/booth_sequencer_if.sv
// Operand/handshake/result bundle between the keypad-entry path and the
// Booth multiplier. The master drives operands and strobes; the slave
// (the multiplier) returns status and the registered product.
interface booth_sequencer_if #(
  parameter int N = 8
);
  logic signed [N-1:0]   op_in;
  logic                  load_a;
  logic                  load_b;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic signed [2*N-1:0] product;

  modport master (
    output op_in, load_a, load_b, start,
    input  busy, done, product
  );

  modport slave (
    input  op_in, load_a, load_b, start,
    output busy, done, product
  );
endinterface

// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplication sequencer. Captures two signed N-bit
// operands, runs one Booth step per clock and presents a registered 2N-bit
// signed product with a one-cycle done pulse. Fixed latency: done is high
// the cycle after edge t0+N+2, where t0 samples start in IDLE.
module booth_sequencer #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth_sequencer_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;      // multiplicand
  logic [N-1:0]   qb_q, qb_d;    // multiplier as loaded
  logic [N-1:0]   q_q, q_d;      // working multiplier / low product half
  logic [N:0]     a_q, a_d;      // one guard bit so -2^(N-1) cannot overflow
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N:0]     m_ext;
  logic [N:0]     a_sum;

  // Booth add/subtract selected by the current bit pair {Q[0], q-1}
  always_comb begin
    m_ext = {m_q[N-1], m_q};
    case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_ext;
      2'b01:   a_sum = a_q + m_ext;
      default: a_sum = a_q;
    endcase
  end

  // Next-state, datapath updates and registered-output next values
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    qb_d    = qb_q;
    q_d     = q_q;
    a_d     = a_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Strobes are only honoured here; INIT reads M/QB one edge later,
        // so a load coinciding with start is used by that multiply.
        if (bus.load_a) m_d  = bus.op_in;
        if (bus.load_b) qb_d = bus.op_in;
        if (bus.start)  state_d = S_INIT;
      end
      S_INIT: begin
        a_d     = '0;
        q_d     = qb_q;
        qm1_d   = 1'b0;
        cnt_d   = CW'(N);
        state_d = S_RUN;
      end
      S_RUN: begin
        // Arithmetic right shift of {A, Q, q-1} after the add/sub
        a_d   = {a_sum[N], a_sum[N:1]};
        q_d   = {a_sum[0], q_q[N-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        prod_d  = {a_q[N-1:0], q_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // busy is registered from the next state so it never overlaps done
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      qb_q    <= '0;
      q_q     <= '0;
      a_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      qb_q    <= qb_d;
      q_q     <= q_d;
      a_q     <= a_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench for booth_sequencer (N = 8) with hand-computed products.
module tb_booth_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  booth_sequencer_if #(.N(8)) bif ();

  booth_sequencer #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    bif.op_in  = a;
    bif.load_a = 1'b1;
    tick();
    bif.load_a = 1'b0;
    bif.op_in  = b;
    bif.load_b = 1'b1;
    tick();
    bif.load_b = 1'b0;
  endtask

  // start is assumed already driven high (possibly with a load) by the caller.
  // The edge sampling start is t0; done must be seen after edge t0+10.
  // When junk is set, strobes are driven a few cycles into the run.
  task automatic run_check(input string tag, input logic [15:0] exp, input bit junk);
    int cyc;
    int busy_cnt;
    int overlap;
    tick();  // edge t0
    bif.start  = 1'b0;
    bif.load_a = 1'b0;
    bif.load_b = 1'b0;
    cyc = 0; busy_cnt = 0; overlap = 0;
    while (bif.done !== 1'b1 && cyc < 40) begin
      if (bif.busy === 1'b1) busy_cnt++;
      if (junk && cyc == 3) begin
        bif.op_in  = 8'd1;
        bif.load_a = 1'b1;
        bif.load_b = 1'b1;
        bif.start  = 1'b1;
      end
      tick();
      bif.load_a = 1'b0;
      bif.load_b = 1'b0;
      bif.start  = 1'b0;
      if (bif.busy === 1'b1 && bif.done === 1'b1) overlap++;
      cyc++;
    end
    chk({tag, "_latency"}, 16'(cyc), 16'd10);
    chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd10);
    chk({tag, "_overlap"}, 16'(overlap), 16'd0);
    chk({tag, "_product"}, bif.product, exp);
    tick();
    chk({tag, "_done_pulse"}, {15'd0, bif.done}, 16'd0);
  endtask

  // Watch a window of cycles and return how many done pulses appeared
  task automatic count_done(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (bif.done === 1'b1) n++;
      tick();
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    bif.op_in  = '0;
    bif.load_a = 1'b0;
    bif.load_b = 1'b0;
    bif.start  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", {15'd0, bif.busy}, 16'd0);
    chk("reset_done", {15'd0, bif.done}, 16'd0);
    chk("reset_product", bif.product, 16'h0000);

    // 3 x 5
    load(8'd3, 8'd5);
    bif.start = 1'b1;
    run_check("m3x5", 16'h000F, 1'b0);

    // -7 x 6, then again with no reload
    load(8'hF9, 8'd6);
    bif.start = 1'b1;
    run_check("mneg7x6", 16'hFFD6, 1'b0);
    tick();
    bif.start = 1'b1;
    run_check("mneg7x6_again", 16'hFFD6, 1'b0);

    // Corner cases
    load(8'h80, 8'h80);
    bif.start = 1'b1;
    run_check("mneg128sq", 16'h4000, 1'b0);
    load(8'h80, 8'h7F);
    bif.start = 1'b1;
    run_check("mneg128x127", 16'hC080, 1'b0);
    load(8'h00, 8'hFF);
    bif.start = 1'b1;
    run_check("m0xneg1", 16'h0000, 1'b0);

    // load_a together with start: the new M is used
    load(8'd0, 8'd2);
    bif.op_in  = 8'd9;
    bif.load_a = 1'b1;
    bif.start  = 1'b1;
    run_check("load_with_start", 16'h0012, 1'b0);

    // Strobes during busy are ignored and not queued
    load(8'd5, 8'd3);
    bif.start = 1'b1;
    run_check("busy_strobes", 16'h000F, 1'b1);
    count_done(15, n);
    chk("busy_strobes_no_extra_done", 16'(n), 16'd0);
    chk("busy_strobes_idle", {15'd0, bif.busy}, 16'd0);
    bif.start = 1'b1;
    run_check("busy_strobes_operands_kept", 16'h000F, 1'b0);

    // Reset in the middle of a run
    load(8'd7, 8'd9);
    bif.start = 1'b1;
    tick();  // edge t0
    bif.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();  // now just after edge t0+4
    rst = 1'b1;
    tick();  // edge t0+5 samples rst
    rst = 1'b0;
    chk("midrst_busy", {15'd0, bif.busy}, 16'd0);
    chk("midrst_product", bif.product, 16'h0000);
    chk("midrst_done", {15'd0, bif.done}, 16'd0);
    count_done(20, n);
    chk("midrst_no_done", 16'(n), 16'd0);
    load(8'd4, 8'd4);
    bif.start = 1'b1;
    run_check("after_rst_4x4", 16'h0010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
